// File: rtl/quick_uart_tx_pkg.sv
// Shared UART definitions: transmitter state encoding, frame length and parity helpers.
// The frame-length and parity helpers are shared with the receiver.
package quick_uart_pkg;

  typedef enum logic [1:0] {
    RESET   = 2'd0,
    IDLE    = 2'd1,
    SENDING = 2'd2
  } uart_tx_state_t;

  function automatic int total_bits(int start_bits, int data_bits, int stop_bits, bit parity);
    return start_bits + data_bits + stop_bits + (parity ? 1 : 0);
  endfunction

  // Zero extension of the word leaves its XOR reduction unchanged.
  function automatic logic parity_bit(logic [63:0] data, logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/quick_uart_tx_if.sv
// Ready/valid word stream feeding the UART transmitter.
// The master modport is the data source; the slave modport is the transmitter.
interface quick_uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic                 valid;
  logic                 ready;
  logic [DATA_BITS-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/quick_uart_tx_piso.sv
// Parallel-in serial-out shift register: bit_o is the LSB, and each advance
// shifts in FILL from the top, so the register drains to the idle level.
module shift_register_piso #(
  parameter int   WIDTH = 10,
  parameter logic FILL  = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             advance_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             bit_o
);

  logic [WIDTH-1:0] shift_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= {WIDTH{FILL}};
    end else if (load_i) begin
      shift_q <= data_i;
    end else if (advance_i) begin
      shift_q <= {FILL, shift_q[WIDTH-1:1]};
    end
  end

  assign bit_o = shift_q[0];

endmodule

// File: rtl/quick_uart_tx.sv
// UART transmitter: frames = start bits, data bits (LSB first), optional parity, stop bits.
// The parity bit is enabled by defining QUICK_UART_TX_PARITY_EN.
module quick_uart_tx
  import quick_uart_pkg::*;
#(
  parameter int   CLK_FREQ   = 100000000,
  parameter int   BAUD       = 115200,
  parameter int   DIV        = CLK_FREQ / BAUD,
  parameter logic IDLE_VALUE = 1'b1,
  parameter int   DATA_BITS  = 8,
  parameter int   STOP_BITS  = 1,
  parameter int   START_BITS = 1,
  parameter logic PARITY_ODD = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  quick_uart_tx_if.slave         s_if,
  output logic                   busy_o,
  output logic                   tx_o
);

`ifdef QUICK_UART_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int TOTAL   = total_bits(START_BITS, DATA_BITS, STOP_BITS, PARITY_EN);
  localparam int TIMER_W = $clog2(DIV + 1);
  localparam int CNT_W   = $clog2(TOTAL) + 1;
  localparam logic [TIMER_W-1:0] DIV_T   = TIMER_W'(DIV);
  localparam logic [CNT_W-1:0]   TOTAL_C = CNT_W'(TOTAL);

  if (DIV < 1) begin : g_div_check
    $error("quick_uart_tx: DIV must be at least 1");
  end
  if (PARITY_ODD > 1'b1) begin : g_parity_check
    $error("quick_uart_tx: PARITY_ODD must be a single bit");
  end

  uart_tx_state_t     state_q;
  logic [TIMER_W-1:0] timer_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [TOTAL-1:0]   frame_d;
  logic               bit_end;
  logic               last_bit_end;
  logic               ready;
  logic               handshake;
  logic               advance;

`ifdef QUICK_UART_TX_PARITY_EN
  assign frame_d = {{STOP_BITS{IDLE_VALUE}},
                    parity_bit(64'(s_if.data), PARITY_ODD),
                    s_if.data,
                    {START_BITS{~IDLE_VALUE}}};
`else
  assign frame_d = {{STOP_BITS{IDLE_VALUE}}, s_if.data, {START_BITS{~IDLE_VALUE}}};
`endif

  assign bit_end      = (state_q == SENDING) && (timer_q == TIMER_W'(1));
  assign last_bit_end = bit_end && (cnt_q == CNT_W'(1));
  // Accepting in the last stop-bit cycle lets a held valid stream gap-free.
  assign ready        = (state_q == IDLE) || last_bit_end;
  assign handshake    = s_if.valid && ready;
  assign advance      = bit_end && !handshake;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RESET;
      timer_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        RESET: state_q <= IDLE;
        IDLE: begin
          if (handshake) begin
            state_q <= SENDING;
            timer_q <= DIV_T;
            cnt_q   <= TOTAL_C;
          end
        end
        SENDING: begin
          if (bit_end) begin
            if (cnt_q == CNT_W'(1)) begin
              if (handshake) begin
                timer_q <= DIV_T;
                cnt_q   <= TOTAL_C;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              timer_q <= DIV_T;
              cnt_q   <= cnt_q - CNT_W'(1);
            end
          end else begin
            timer_q <= timer_q - TIMER_W'(1);
          end
        end
        default: state_q <= RESET;
      endcase
    end
  end

  shift_register_piso #(
    .WIDTH (TOTAL),
    .FILL  (IDLE_VALUE)
  ) u_piso (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (handshake),
    .advance_i (advance),
    .data_i    (frame_d),
    .bit_o     (tx_o)
  );

  assign s_if.ready = ready;
  assign busy_o     = (state_q == SENDING);

endmodule

// File: tb/tb_quick_uart_tx.sv
// Directed bench for quick_uart_tx: an 8N1 DIV=4 instance and a 2-start/5-data/2-stop DIV=1 instance.
module tb_quick_uart_tx;

`ifdef QUICK_UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int DIV_A = 4;
  localparam int DIV_B = 1;
  localparam int FL_A  = 10 + PAR;
  localparam int FL_B  = 9 + PAR;

  logic clk;
  logic rst_n;
  logic busy_a, tx_a, busy_b, tx_b;
  int   total = 0;
  int   bad   = 0;
  logic exp_q[$];

  quick_uart_tx_if #(.DATA_BITS(8)) if_a ();
  quick_uart_tx_if #(.DATA_BITS(5)) if_b ();

  quick_uart_tx #(
    .DIV(DIV_A), .IDLE_VALUE(1'b1), .DATA_BITS(8), .STOP_BITS(1), .START_BITS(1), .PARITY_ODD(1'b0)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .s_if(if_a.slave), .busy_o(busy_a), .tx_o(tx_a)
  );

  quick_uart_tx #(
    .DIV(DIV_B), .IDLE_VALUE(1'b1), .DATA_BITS(5), .STOP_BITS(2), .START_BITS(2), .PARITY_ODD(1'b1)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .s_if(if_b.slave), .busy_o(busy_b), .tx_o(tx_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: start bits, data LSB first, optional parity, stop bits.
  task automatic push_frame(input int sel, input logic [7:0] d);
    int ns, nd, nst;
    if (sel == 0) begin ns = 1; nd = 8; nst = 1; end
    else          begin ns = 2; nd = 5; nst = 2; end
    repeat (ns) exp_q.push_back(1'b0);
    for (int i = 0; i < nd; i++) exp_q.push_back(d[i]);
`ifdef QUICK_UART_TX_PARITY_EN
    begin
      logic p;
      p = (sel == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < nd; i++) p = p ^ d[i];
      exp_q.push_back(p);
    end
`endif
    repeat (nst) exp_q.push_back(1'b1);
  endtask

  function automatic logic tx_of(input int sel);
    return (sel == 0) ? tx_a : tx_b;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic ready_of(input int sel);
    return (sel == 0) ? if_a.ready : if_b.ready;
  endfunction

  task automatic hs(input int sel, input logic [7:0] d, input bit keep);
    int n;
    n = 0;
    if (sel == 0) begin if_a.valid = 1'b1; if_a.data = d; end
    else          begin if_b.valid = 1'b1; if_b.data = d[4:0]; end
    @(negedge clk);
    while (!ready_of(sel) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("hs_wait", 32'(n < 200), 32'd1);
    push_frame(sel, d);
    @(posedge clk);
    #1;
    if (!keep) begin
      if (sel == 0) if_a.valid = 1'b0;
      else          if_b.valid = 1'b0;
    end
  endtask

  task automatic check_bits(input int sel, input int div, input int flen, input int nbits);
    logic b;
    for (int j = 0; j < nbits; j++) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd0, 32'd1);
        return;
      end
      b = exp_q.pop_front();
      for (int c = 0; c < div; c++) begin
        @(negedge clk);
        chk("tx_bit", 32'(tx_of(sel)), 32'(b));
        chk("busy", 32'(busy_of(sel)), 32'd1);
        if ((j % flen) == flen - 1 && c == div - 1)
          chk("ready_last", 32'(ready_of(sel)), 32'd1);
        else if ((j % flen) == 0 && c == 0)
          chk("ready_first", 32'(ready_of(sel)), 32'd0);
      end
    end
  endtask

  task automatic check_idle(input int sel);
    @(negedge clk);
    chk("idle_tx", 32'(tx_of(sel)), 32'd1);
    chk("idle_busy", 32'(busy_of(sel)), 32'd0);
    chk("idle_ready", 32'(ready_of(sel)), 32'd1);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    if_a.valid = 1'b0; if_a.data = '0;
    if_b.valid = 1'b0; if_b.data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_a", 32'(tx_a), 32'd1);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_ready_a", 32'(if_a.ready), 32'd0);
    chk("rst_ready_b", 32'(if_b.ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(if_a.ready), 32'd0);
    check_idle(0);

    // Basic frame 8'hA5
    hs(0, 8'hA5, 1'b0);
    check_bits(0, DIV_A, FL_A, FL_A);
    check_idle(0);

    // Back-to-back with valid held: 8'h00 then 8'hFF, no idle gap
    hs(0, 8'h00, 1'b1);
    if_a.data = 8'hFF;
    push_frame(0, 8'hFF);
    fork
      begin
        repeat (FL_A * DIV_A) @(posedge clk);
        #1;
        if_a.valid = 1'b0;
      end
    join_none
    check_bits(0, DIV_A, FL_A, 2 * FL_A);
    check_idle(0);

    // Data stability: change data_i after the handshake
    hs(0, 8'h3C, 1'b0);
    if_a.data = 8'hC3;
    check_bits(0, DIV_A, FL_A, FL_A);
    check_idle(0);
    hs(0, 8'hC3, 1'b0);
    check_bits(0, DIV_A, FL_A, FL_A);
    check_idle(0);

    // Parity-relevant word
    hs(0, 8'h07, 1'b0);
    check_bits(0, DIV_A, FL_A, FL_A);
    check_idle(0);

    // Reset during data bit 3 (frame bit 4)
    hs(0, 8'hA5, 1'b0);
    check_bits(0, DIV_A, FL_A, 4);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx_a), 32'd1);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_ready", 32'(if_a.ready), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready0", 32'(if_a.ready), 32'd0);
    chk("rel_tx", 32'(tx_a), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("rel_ready1", 32'(if_a.ready), 32'd1);
    chk("rel_busy", 32'(busy_a), 32'd0);
    hs(0, 8'h55, 1'b0);
    check_bits(0, DIV_A, FL_A, FL_A);
    check_idle(0);

    // DIV=1, 2 start, 5 data, 2 stop
    check_idle(1);
    hs(1, 8'h11, 1'b0);
    check_bits(1, DIV_B, FL_B, FL_B);
    check_idle(1);

    // DIV=1 back-to-back streaming
    hs(1, 8'h0A, 1'b1);
    if_b.data = 5'h15;
    push_frame(1, 8'h15);
    fork
      begin
        repeat (FL_B * DIV_B) @(posedge clk);
        #1;
        if_b.valid = 1'b0;
      end
    join_none
    check_bits(1, DIV_B, FL_B, 2 * FL_B);
    check_idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
